// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register bank's single write port between ALU writeback, load
// writeback and PC update, and tracks outstanding register writes for hazard stalls.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned REG_W        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alu_req,
  input  logic [REG_W-1:0]      i_alu_reg,
  input  logic [DATA_W-1:0]     i_alu_data,
  output logic                  o_alu_ack,
  input  logic                  i_mem_req,
  input  logic [REG_W-1:0]      i_mem_reg,
  input  logic [DATA_W-1:0]     i_mem_data,
  output logic                  o_mem_ack,
  input  logic                  i_pc_req,
  input  logic [DATA_W-1:0]     i_pc_data,
  output logic                  o_pc_ack,
  output logic                  o_wr_en,
  output logic [REG_W-1:0]      o_wr_reg,
  output logic [DATA_W-1:0]     o_wr_data,
  output logic                  o_pc_inc,
  output logic [DATA_W-1:0]     o_pc_data_in,
  input  logic                  i_issue_en,
  input  logic [REG_W-1:0]      i_issue_reg,
  input  logic [REG_W-1:0]      i_src_reg,
  input  logic [REG_W-1:0]      i_dst_reg,
  output logic [(2**REG_W)-1:0] o_busy,
  output logic                  o_src_busy_c,
  output logic                  o_dst_busy_c
);

  localparam int unsigned NREG  = 2**REG_W;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_MEM, GNT_PC} gnt_e;

  logic              r_alu_ack, r_mem_ack, r_pc_ack;
  logic              r_wr_en, r_pc_inc;
  logic [REG_W-1:0]  r_wr_reg;
  logic [DATA_W-1:0] r_wr_data, r_pc_data_in;
  logic [NREG-1:0]   r_busy;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_last_mem;

  logic              w_alu_elig, w_mem_elig, w_pc_elig, w_pc_starved;
  gnt_e              w_gnt;
  logic [NREG-1:0]   w_busy_nxt;

  // A requester whose ack is currently high is still holding req from the
  // granted transfer, so it must not be granted a second time.
  assign w_alu_elig   = i_alu_req && !r_alu_ack;
  assign w_mem_elig   = i_mem_req && !r_mem_ack;
  assign w_pc_elig    = i_pc_req  && !r_pc_ack;
  assign w_pc_starved = w_pc_elig && (r_starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Priority: starved PC, then ALU/MEM round-robin, then PC.
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_pc_starved)                w_gnt = GNT_PC;
    else if (w_alu_elig && w_mem_elig) w_gnt = r_last_mem ? GNT_ALU : GNT_MEM;
    else if (w_alu_elig)             w_gnt = GNT_ALU;
    else if (w_mem_elig)             w_gnt = GNT_MEM;
    else if (w_pc_elig)              w_gnt = GNT_PC;
  end

  // Scoreboard: the issue-time set is applied last so it wins over a same-cycle clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt == GNT_ALU) w_busy_nxt[i_alu_reg] = 1'b0;
    if (w_gnt == GNT_MEM) w_busy_nxt[i_mem_reg] = 1'b0;
    if (i_issue_en)       w_busy_nxt[i_issue_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_ack    <= 1'b0;
      r_mem_ack    <= 1'b0;
      r_pc_ack     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_pc_inc     <= 1'b0;
      r_wr_reg     <= '0;
      r_wr_data    <= '0;
      r_pc_data_in <= '0;
      r_busy       <= '0;
      r_starve_cnt <= '0;
      r_last_mem   <= 1'b1;
    end else begin
      r_alu_ack <= (w_gnt == GNT_ALU);
      r_mem_ack <= (w_gnt == GNT_MEM);
      r_pc_ack  <= (w_gnt == GNT_PC);
      r_wr_en   <= (w_gnt == GNT_ALU) || (w_gnt == GNT_MEM);
      r_pc_inc  <= (w_gnt == GNT_PC);
      r_busy    <= w_busy_nxt;

      case (w_gnt)
        GNT_ALU: begin
          r_wr_reg   <= i_alu_reg;
          r_wr_data  <= i_alu_data;
          r_last_mem <= 1'b0;
        end
        GNT_MEM: begin
          r_wr_reg   <= i_mem_reg;
          r_wr_data  <= i_mem_data;
          r_last_mem <= 1'b1;
        end
        GNT_PC:  r_pc_data_in <= i_pc_data;
        default: ;
      endcase

      if (!i_pc_req || (w_gnt == GNT_PC))
        r_starve_cnt <= '0;
      else if (w_pc_elig && (r_starve_cnt < CNT_W'(STARVE_LIMIT)))
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign o_alu_ack    = r_alu_ack;
  assign o_mem_ack    = r_mem_ack;
  assign o_pc_ack     = r_pc_ack;
  assign o_wr_en      = r_wr_en;
  assign o_wr_reg     = r_wr_reg;
  assign o_wr_data    = r_wr_data;
  assign o_pc_inc     = r_pc_inc;
  assign o_pc_data_in = r_pc_data_in;
  assign o_busy       = r_busy;
  assign o_src_busy_c = r_busy[i_src_reg];
  assign o_dst_busy_c = r_busy[i_dst_reg];

endmodule
